// File: rtl/cam_stream_gen_if.sv
`timescale 1ns/1ps
// Video output bus of the OV7670-style pattern source: sync, byte stream and frame status.
interface cam_stream_gen_if;
   logic        vsync;
   logic        href;
   logic [7:0]  px_data;
   logic        frame_done;
   logic [15:0] frame_cnt;

   modport master (output vsync, href, px_data, frame_done, frame_cnt);
   modport slave  (input  vsync, href, px_data, frame_done, frame_cnt);
endinterface

// File: rtl/cam_stream_gen.sv
`timescale 1ns/1ps
// OV7670-style RGB565 test-pattern source; all state and outputs change on the falling
// pclk edge so a rising-edge capture block samples stable vsync/href/px_data.
module cam_stream_gen #(
   parameter int unsigned H_ACTIVE    = 160,
   parameter int unsigned H_BLANK     = 16,
   parameter int unsigned V_ACTIVE    = 120,
   parameter int unsigned VSYNC_LINES = 3,
   parameter int unsigned V_BACK      = 2,
   parameter int unsigned V_FRONT     = 2
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [15:0]      color,
   cam_stream_gen_if.master vid
);
   localparam int unsigned LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
   localparam int unsigned ACT_BYTES = 2 * H_ACTIVE;
   localparam int unsigned MAX_A     = (VSYNC_LINES > V_ACTIVE) ? VSYNC_LINES : V_ACTIVE;
   localparam int unsigned MAX_B     = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
   localparam int unsigned MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned HW        = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
   localparam int unsigned VW        = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

   typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

   // The frame ends in VFRONT, or in ACTIVE when the front porch is configured away.
   localparam state_t      LAST_ST    = (V_FRONT != 0) ? VFRONT : ACTIVE;
   localparam int unsigned LAST_LINES = (V_FRONT != 0) ? V_FRONT : V_ACTIVE;

   state_t          state, nxt_state;
   logic [HW-1:0]   h_cnt, nxt_h;
   logic [VW-1:0]   v_cnt, nxt_v;
   logic [1:0]      mode_q;
   logic [15:0]     color_q;
   logic            latch;
   int unsigned     seg_lines;
   logic            line_end;
   logic            seg_end;

   logic [15:0]     px_x;
   logic [15:0]     px_y;
   logic [2:0]      bar;
   logic [15:0]     pix;
   logic            nxt_href;
   logic [7:0]      nxt_byte;
   logic            nxt_last;

   function automatic logic [15:0] bar_color(input logic [2:0] b);
      case (b)
         3'd0:    bar_color = 16'hFFFF;
         3'd1:    bar_color = 16'hFFE0;
         3'd2:    bar_color = 16'h07FF;
         3'd3:    bar_color = 16'h07E0;
         3'd4:    bar_color = 16'hF81F;
         3'd5:    bar_color = 16'hF800;
         3'd6:    bar_color = 16'h001F;
         default: bar_color = 16'h0000;
      endcase
   endfunction

   // State and position counters; pattern selection is captured only at frame start.
   always_ff @(negedge pclk) begin
      if (rst) begin
         state   <= IDLE;
         h_cnt   <= '0;
         v_cnt   <= '0;
         mode_q  <= '0;
         color_q <= '0;
      end else begin
         state <= nxt_state;
         h_cnt <= nxt_h;
         v_cnt <= nxt_v;
         if (latch) begin
            mode_q  <= mode;
            color_q <= color;
         end
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_h     = h_cnt;
      nxt_v     = v_cnt;
      latch     = 1'b0;
      case (state)
         VSYNC:   seg_lines = VSYNC_LINES;
         VBACK:   seg_lines = V_BACK;
         ACTIVE:  seg_lines = V_ACTIVE;
         VFRONT:  seg_lines = V_FRONT;
         default: seg_lines = 1;
      endcase
      line_end = (32'(h_cnt) == LINE_LEN - 1);
      seg_end  = line_end && (32'(v_cnt) == seg_lines - 1);

      if (state == IDLE) begin
         if (en) begin
            nxt_state = VSYNC;
            nxt_h     = '0;
            nxt_v     = '0;
            latch     = 1'b1;
         end
      end else if (seg_end) begin
         nxt_h = '0;
         nxt_v = '0;
         if (state == LAST_ST) begin
            nxt_state = en ? VSYNC : IDLE;
            latch     = en;
         end else if (state == VSYNC) begin
            nxt_state = (V_BACK != 0) ? VBACK : ACTIVE;
         end else if (state == VBACK) begin
            nxt_state = ACTIVE;
         end else begin
            nxt_state = VFRONT;
         end
      end else if (line_end) begin
         nxt_h = '0;
         nxt_v = v_cnt + VW'(1);
      end else begin
         nxt_h = h_cnt + HW'(1);
      end
   end

   // Pattern and sync values for the position the counters move to on this edge.
   always_comb begin
      px_x     = 16'(nxt_h >> 1);
      px_y     = 16'(nxt_v);
      bar      = 3'((32'(px_x) * 32'd8) / H_ACTIVE);
      pix      = 16'h0000;
      case (mode_q)
         2'd0:    pix = bar_color(bar);
         2'd1:    pix = {px_x[4:0], px_y[5:0], px_x[4:0]};
         2'd2:    pix = color_q;
         default: pix = 16'(32'(px_y) * H_ACTIVE + 32'(px_x));
      endcase
      nxt_href = (nxt_state == ACTIVE) && (32'(nxt_h) < ACT_BYTES);
      nxt_byte = 8'h00;
      if (nxt_href) begin
         nxt_byte = nxt_h[0] ? pix[7:0] : pix[15:8];
      end
      nxt_last = (nxt_state == LAST_ST)
              && (32'(nxt_v) == LAST_LINES - 1)
              && (32'(nxt_h) == LINE_LEN - 1);
   end

   always_ff @(negedge pclk) begin
      if (rst) begin
         vid.vsync      <= 1'b0;
         vid.href       <= 1'b0;
         vid.px_data    <= 8'h00;
         vid.frame_done <= 1'b0;
         vid.frame_cnt  <= 16'h0000;
      end else begin
         vid.vsync      <= (nxt_state == VSYNC);
         vid.href       <= nxt_href;
         vid.px_data    <= nxt_byte;
         vid.frame_done <= nxt_last;
         if (nxt_last) begin
            vid.frame_cnt <= vid.frame_cnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_cam_stream_gen.sv
`timescale 1ns/1ps
// Scoreboard bench for cam_stream_gen: a small-geometry instance for frame timing and
// patterns, and a default-geometry instance for QQVGA colour bars.
module tb_cam_stream_gen;
   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic        s_rst, s_en, d_rst, d_en;
   logic [1:0]  s_mode, d_mode;
   logic [15:0] s_color, d_color;

   cam_stream_gen_if s_if ();
   cam_stream_gen_if d_if ();

   cam_stream_gen #(.H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3),
                    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)) u_small (
      .pclk(pclk), .rst(s_rst), .en(s_en), .mode(s_mode), .color(s_color), .vid(s_if.master));

   cam_stream_gen u_dflt (
      .pclk(pclk), .rst(d_rst), .en(d_en), .mode(d_mode), .color(d_color), .vid(d_if.master));

   typedef struct { int line; int idx; logic [7:0] val; } dchk_t;

   int          total = 0;
   int          bad   = 0;
   bit          s_done = 1'b0;
   bit          d_done = 1'b0;
   bit          d_fd_seen = 1'b0;
   logic [7:0]  exp_q[$];
   int          fcnt_q[$];
   dchk_t       dchk_q[$];
   logic [15:0] bars4 [4] = '{16'hFFFF, 16'h07FF, 16'hF81F, 16'h001F};

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(negedge pclk);
      #1;
   endtask

   task automatic push_px(input logic [15:0] p);
      exp_q.push_back(p[15:8]);
      exp_q.push_back(p[7:0]);
   endtask

   task automatic push_dchk(input int l, input int i, input logic [7:0] v);
      dchk_t c;
      c.line = l;
      c.idx  = i;
      c.val  = v;
      dchk_q.push_back(c);
   endtask

   task automatic wait_s_fd(input string name);
      int n = 0;
      while (!s_if.frame_done && n < 200) begin
         step();
         n++;
      end
      if (!s_if.frame_done) begin
         total++;
         bad++;
         $display("FAIL %s: frame_done not seen within %0d cycles", name, n);
      end
      step();
   endtask

   task automatic wait_s_href(input string name);
      int n = 0;
      while (!s_if.href && n < 200) begin
         step();
         n++;
      end
      if (!s_if.href) begin
         total++;
         bad++;
         $display("FAIL %s: href not seen within %0d cycles", name, n);
      end
   endtask

   task automatic chk_s_quiet(input string tag);
      chk({tag, "_vsync"}, int'(s_if.vsync), 0);
      chk({tag, "_href"}, int'(s_if.href), 0);
      chk({tag, "_px"}, int'(s_if.px_data), 0);
      chk({tag, "_fdone"}, int'(s_if.frame_done), 0);
   endtask

   // Small-instance monitor: byte scoreboard, run lengths and per-frame totals.
   bit         s_prev_vs, s_prev_hr;
   int         s_vs_run, s_hr_run, s_lines, s_pix, s_fcyc;
   logic [7:0] s_e;
   int         s_f;
   always @(posedge pclk) begin
      if (s_rst) begin
         s_prev_vs = 1'b0; s_prev_hr = 1'b0;
         s_vs_run = 0; s_hr_run = 0; s_lines = 0; s_pix = 0; s_fcyc = 0;
      end else begin
         if (s_if.vsync) s_vs_run++;
         else if (s_prev_vs) begin
            chk("vsync_len", s_vs_run, 10);
            s_vs_run = 0;
         end
         if (s_if.vsync && !s_prev_vs) s_fcyc = 1;
         else if (s_fcyc != 0) s_fcyc++;
         if (s_if.href) begin
            s_hr_run++;
            if (s_hr_run % 2 == 0) s_pix++;
            if (exp_q.size() == 0) chk("px_unexpected", int'(s_if.px_data), -1);
            else begin
               s_e = exp_q.pop_front();
               chk("px_byte", int'(s_if.px_data), int'(s_e));
            end
         end else begin
            chk("px_blank", int'(s_if.px_data), 0);
            if (s_prev_hr) begin
               chk("href_len", s_hr_run, 8);
               s_lines++;
               s_hr_run = 0;
            end
         end
         if (s_if.frame_done) begin
            if (fcnt_q.size() == 0) chk("frame_done_unexpected", 1, 0);
            else begin
               s_f = fcnt_q.pop_front();
               chk("frame_cnt", int'(s_if.frame_cnt), s_f);
            end
            chk("frame_len", s_fcyc, 60);
            chk("frame_lines", s_lines, 3);
            chk("frame_pixels", s_pix, 12);
            s_lines = 0; s_pix = 0; s_fcyc = 0;
         end
         s_prev_vs = s_if.vsync;
         s_prev_hr = s_if.href;
      end
   end

   // Default-instance monitor: spot-checked bytes plus line count and line length.
   bit    d_prev_vs, d_prev_hr;
   int    d_hr_run, d_lines;
   dchk_t d_c;
   always @(posedge pclk) begin
      if (d_rst) begin
         d_prev_vs = 1'b0; d_prev_hr = 1'b0; d_hr_run = 0; d_lines = 0;
      end else begin
         if (d_if.vsync && !d_prev_vs) d_lines = 0;
         if (d_if.href) begin
            if (dchk_q.size() != 0 && dchk_q[0].line == d_lines && dchk_q[0].idx == d_hr_run) begin
               d_c = dchk_q.pop_front();
               chk($sformatf("dflt_px L%0d B%0d", d_c.line, d_c.idx), int'(d_if.px_data), int'(d_c.val));
            end
            d_hr_run++;
         end else begin
            chk("dflt_px_blank", int'(d_if.px_data), 0);
            if (d_prev_hr) begin
               chk("dflt_href_len", d_hr_run, 320);
               d_lines++;
               d_hr_run = 0;
            end
         end
         if (d_if.frame_done) begin
            chk("dflt_lines", d_lines, 120);
            chk("dflt_frame_cnt", int'(d_if.frame_cnt), 1);
            d_fd_seen = 1'b1;
         end
         d_prev_vs = d_if.vsync;
         d_prev_hr = d_if.href;
      end
   end

   // Small-instance stimulus.
   initial begin
      s_rst = 1'b1; s_en = 1'b0; s_mode = 2'd0; s_color = 16'h0000;
      step();
      step();
      chk_s_quiet("rst");
      chk("rst_frame_cnt", int'(s_if.frame_cnt), 0);

      s_mode = 2'd2; s_color = 16'hA5C3;
      for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) push_px(16'hA5C3);
      fcnt_q.push_back(1);
      s_rst = 1'b0; s_en = 1'b1;
      step();
      chk("vsync_start", int'(s_if.vsync), 1);

      s_mode = 2'd3;
      for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) push_px(16'(y * 4 + x));
      fcnt_q.push_back(2);
      wait_s_fd("frame1");

      s_mode = 2'd1;
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 4; x++) push_px(16'((x << 11) | (y << 5) | x));
      fcnt_q.push_back(3);
      wait_s_fd("frame2");

      s_mode = 2'd0;
      for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) push_px(bars4[x]);
      fcnt_q.push_back(4);
      wait_s_fd("frame3");

      wait_s_href("frame4_href");
      s_en = 1'b0; s_mode = 2'd2;
      wait_s_fd("frame4");
      for (int i = 0; i < 6; i++) begin
         chk_s_quiet("idle");
         step();
      end
      chk("idle_frame_cnt", int'(s_if.frame_cnt), 4);

      s_mode = 2'd2; s_color = 16'h1234; s_en = 1'b1;
      for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) push_px(16'h1234);
      step();
      chk("vsync_restart", int'(s_if.vsync), 1);
      wait_s_href("frame5_href");
      step();
      step();
      s_rst = 1'b1;
      step();
      chk_s_quiet("rst_mid");
      chk("rst_mid_frame_cnt", int'(s_if.frame_cnt), 0);
      exp_q.delete();
      fcnt_q.delete();

      s_mode = 2'd3;
      for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) push_px(16'(y * 4 + x));
      fcnt_q.push_back(1);
      s_rst = 1'b0;
      step();
      chk("vsync_after_rst", int'(s_if.vsync), 1);
      s_en = 1'b0;
      wait_s_fd("frame6");
      step();
      chk_s_quiet("final_idle");
      s_done = 1'b1;
   end

   // Default-instance stimulus: one QQVGA colour-bar frame.
   initial begin
      int n;
      d_rst = 1'b1; d_en = 1'b0; d_mode = 2'd0; d_color = 16'h0000;
      push_dchk(0, 0, 8'hFF);   push_dchk(0, 1, 8'hFF);
      push_dchk(0, 40, 8'hFF);  push_dchk(0, 41, 8'hE0);
      push_dchk(0, 80, 8'h07);  push_dchk(0, 81, 8'hFF);
      push_dchk(0, 318, 8'h00); push_dchk(0, 319, 8'h00);
      push_dchk(60, 160, 8'hF8); push_dchk(60, 161, 8'h1F);
      push_dchk(119, 2, 8'hFF); push_dchk(119, 319, 8'h00);
      step();
      step();
      d_rst = 1'b0; d_en = 1'b1;
      step();
      chk("dflt_vsync_start", int'(d_if.vsync), 1);
      d_en = 1'b0; d_mode = 2'd2;
      n = 0;
      while (!d_fd_seen && n < 50000) begin
         step();
         n++;
      end
      if (!d_fd_seen) begin
         total++;
         bad++;
         $display("FAIL dflt_frame_done: not seen within %0d cycles", n);
      end
      step();
      step();
      chk("dflt_idle_vsync", int'(d_if.vsync), 0);
      chk("dflt_idle_href", int'(d_if.href), 0);
      d_done = 1'b1;
   end

   initial begin
      wait (s_done && d_done);
      chk("exp_q_left", exp_q.size(), 0);
      chk("fcnt_q_left", fcnt_q.size(), 0);
      chk("dchk_q_left", dchk_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/cam_stream_gen.md
Name: cam_stream_gen

Overview:
- Synthesizable OV7670-style video source: emits vsync, href and 8-bit px_data with the same timing and byte order the camera capture path expects.
- Transmit-side counterpart of the capture block; used in simulation and on-board loopback to drive the capture-to-framebuffer path without a physical sensor.
- Generates RGB565 test patterns, two bytes per pixel, default QQVGA 160x120.

Parameters:
H_ACTIVE, 160, active pixels per line (each pixel is 2 bytes, so 2*H_ACTIVE byte cycles)
H_BLANK, 16, pclk cycles per line with href low
V_ACTIVE, 120, active lines per frame
VSYNC_LINES, 3, lines with vsync high
V_BACK, 2, blank lines after vsync, before the first active line
V_FRONT, 2, blank lines after the last active line

Ports:
pclk  input  1  pixel clock; all state updates on the falling edge so a rising-edge receiver samples stable data
rst  input  1  synchronous active-high reset, sampled on falling pclk
en  input  1  run enable; sampled only at frame boundaries
mode  input  2  pattern select; latched at frame start
color  input  16  RGB565 value for solid mode; latched at frame start
vsync  output  1  frame sync, high during VSYNC_LINES
href  output  1  high while active bytes are on px_data
px_data  output  8  pixel byte stream
frame_done  output  1  one-cycle pulse on the last cycle of each frame
frame_cnt  output  16  completed-frame count, wraps at 0xFFFF->0

Behaviour:
- Reset (rst=1 at a falling edge): vsync=0, href=0, px_data=0, frame_done=0, frame_cnt=0. All counters are cleared and the block goes to IDLE. Reset mid-frame aborts the frame immediately; no frame_done is pulsed.
- Line length L = 2*H_ACTIVE + H_BLANK cycles. Frame length = (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*L cycles.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE: all outputs low. If en=1, latch mode and color, then go to VSYNC. vsync=1 appears on the first falling edge after leaving IDLE.
  - VSYNC: vsync=1 for VSYNC_LINES*L cycles, href=0.
  - VBACK: V_BACK*L cycles, all outputs low.
  - ACTIVE: V_ACTIVE lines. Each line drives href=1 and valid px_data for h_cnt 0..2*H_ACTIVE-1, then href=0 and px_data=0 for H_BLANK cycles.
  - VFRONT: V_FRONT*L cycles. frame_done=1 on its final cycle, and frame_cnt increments on that same edge.
  - After VFRONT: if en=1, re-latch mode and color and go to VSYNC with no gap cycle; otherwise go to IDLE.
- en=0 mid-frame has no effect until the frame completes.
- A parameter value of 0 for V_BACK or V_FRONT skips that state. VSYNC_LINES, V_ACTIVE and H_ACTIVE must be >= 1.
- Byte order: for pixel x (x = h_cnt>>1), an even h_cnt carries P[15:8] and an odd h_cnt carries P[7:0], where P is the RGB565 pixel.
- Patterns (y = active line index 0..V_ACTIVE-1):
  - mode 0, colour bars: bar = (x*8)/H_ACTIVE. Values 0..7 in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - mode 1, gradient: P = {x[4:0], y[5:0], x[4:0]}.
  - mode 2, solid: P = latched color.
  - mode 3, counter: P = (y*H_ACTIVE + x) mod 2^16.
- All pattern arithmetic is unsigned and truncated to 16 bits. Outputs are registered, with no combinational paths from inputs to outputs.

Test Plan:
1. Params H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1; rst 2 cycles, then en=1 -> vsync high for exactly 10 cycles; href high 8 cycles per line for 3 lines; frame_done pulses once at cycle 60; frame_cnt=1.
2. Same params, mode=2, color=16'hA5C3 -> every active line carries the bytes A5,C3,A5,C3,A5,C3,A5,C3; px_data=0 whenever href=0.
3. mode=3 -> line y=2 carries the bytes 00,08,00,09,00,0A,00,0B.
4. Default params, mode=0 -> line 0, pixel 0 = FF,FF; pixel 20 = FF,E0; pixel 159 = 00,00. Per frame: 120 href pulses of 320 cycles each.
5. en dropped mid-ACTIVE -> the current frame completes with frame_done; the block then stays in IDLE with all outputs 0. Raising en again starts vsync on the next falling edge. A mode change mid-frame does not affect the current frame.
6. rst asserted during ACTIVE -> outputs 0 on the next falling edge, frame_cnt=0, no frame_done. Connected to the capture block, a full frame produces exactly H_ACTIVE*V_ACTIVE write strobes.
